timer_irq: RTL
==============

// Module: timer_irq
// PURPOSE
//  Programmable interval timer feeding the CPU interrupt inputs. Takes the
//  timer-config instruction (opcode 101001: enable[1] base[3] umbral[6]),
//  decoded upstream by the control unit. Counts prescaled ticks up to the
//  threshold, then raises a latched interrupt request that the CPU acknowledges.
//  Sits between the control unit / instruction field path and one ieN input.
// PARAMETERS
//  PRESC_W   8  prescaler counter width; must be >= 7 so base=7 (128 cycles) fits
//  CNT_W     6  tick counter width; equals umbral field width
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high
//  cfg_we      in   1      one-cycle strobe: timer-config instruction decoded
//  cfg_enable  in   1      opcode[9]: 1=run, 0=stop
//  cfg_base    in   3      opcode[8:6]: tick period = 2^base clk cycles
//  cfg_umbral  in   CNT_W  opcode[5:0]: ticks per interrupt; 0 = never fire
//  irq_ack     in   1      one-cycle acknowledge from CPU interrupt logic
//  irq         out  1      interrupt request, level, held until acked
//  overrun     out  1      sticky: a fire occurred while irq already pending
//  count       out  CNT_W  current tick count (debug/readback)
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, count=0, base_r=0, umbral_r=0, irq=0, overrun=0.
//  States: IDLE (not counting), RUN (counting).
//  cfg_we=1: base_r<=cfg_base, umbral_r<=cfg_umbral, prescaler<=0, count<=0.
//   Next state is RUN if cfg_enable=1, else IDLE. irq and overrun are left unchanged.
//   cfg_we always wins over tick logic in the same cycle (restart mid-run).
//  IDLE: prescaler and count hold. No ticks or fires occur.
//  RUN, per clk:
//   - prescaler == 2^base_r - 1 -> tick: prescaler<=0; otherwise prescaler<=prescaler+1.
//   - On a tick with umbral_r != 0:
//     - count == umbral_r-1 -> fire: count<=0.
//     - otherwise count<=count+1.
//   - umbral_r == 0 -> count holds 0 and no fire occurs; prescaler still runs.
//  Fire -> irq<=1 (visible cycle after the tick edge).
//   If irq is already 1 and irq_ack=0 that cycle, overrun<=1.
//  irq_ack=1 -> irq<=0, unless a fire occurs in the same cycle; then irq stays 1
//   and overrun is not set. The ack also clears overrun.
//  irq_ack with irq=0 has no effect.
//  Latency: irq rises exactly umbral*2^base clk edges after the cfg_we edge.
//   Auto-reload gives period umbral*2^base.
//  Width rules: all counters are unsigned, compares are exact, no saturation.
//   base=0 -> tick every cycle.
//  Reset asserted mid-count: everything returns to reset values immediately
//   (async); timer stays IDLE until a new cfg_we.
// TESTING
//  1. Reset, then cfg_we en=1 base=0 umbral=3 -> irq rises after 3rd edge;
//     count shows 1,2,0.
//  2. base=2 umbral=5, no ack -> irq at 20 edges, overrun at 40 edges,
//     irq stays 1; ack -> both 0.
//  3. Ack on the exact cycle of a fire (base=0 umbral=1) -> irq stays 1,
//     overrun stays 0.
//  4. umbral=0 en=1 for 500 cycles -> irq=0, count=0 throughout.
//  5. Reconfigure at count=4 (umbral=10 -> umbral=2) -> count restarts at 0,
//     irq after 2*2^base edges.
//  6. Async reset pulse between clk edges mid-RUN -> irq, overrun, count = 0
//     at once; no fires until next cfg_we.

Source files
------------

// File: rtl/timer_irq.sv
// timer_irq: programmable interval timer driving one CPU interrupt input.
// A config strobe loads tick period (2^base cycles) and threshold (umbral
// ticks); each time the threshold is reached a latched irq is raised and
// held until the CPU acknowledges it. A fire while irq is still pending
// sets the sticky overrun flag.
module timer_irq #(
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic             cfg_enable,
    input  logic [2:0]       cfg_base,
    input  logic [CNT_W-1:0] cfg_umbral,
    input  logic             irq_ack,
    output logic             irq,
    output logic             overrun,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_ONES = '1;

    state_t             state, state_nx;
    logic [PRESC_W-1:0] presc, presc_nx, presc_lim;
    logic [CNT_W-1:0]   count_r, count_nx;
    logic [CNT_W-1:0]   umbral_r;
    logic [2:0]         base_r;
    logic               irq_r, ovr_r;
    logic               tick, fire;

    // Terminal prescaler value 2^base_r - 1 as a low-order mask of ones.
    always_comb begin
        presc_lim = ~(PRESC_ONES << base_r);
    end

    // Next-state and counter logic; a config strobe overrides ticking.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        count_nx = count_r;
        tick     = 1'b0;
        fire     = 1'b0;
        if (cfg_we) begin
            state_nx = cfg_enable ? RUN : IDLE;
            presc_nx = '0;
            count_nx = '0;
        end else if (state == RUN) begin
            tick     = (presc == presc_lim);
            presc_nx = tick ? '0 : presc + PRESC_W'(1);
            if (tick && (umbral_r != '0)) begin
                if (count_r == umbral_r - CNT_W'(1)) begin
                    fire     = 1'b1;
                    count_nx = '0;
                end else begin
                    count_nx = count_r + CNT_W'(1);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Configuration and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r   <= '0;
            umbral_r <= '0;
            presc    <= '0;
            count_r  <= '0;
        end else begin
            if (cfg_we) begin
                base_r   <= cfg_base;
                umbral_r <= cfg_umbral;
            end
            presc   <= presc_nx;
            count_r <= count_nx;
        end
    end

    // Interrupt request and sticky overrun; a fire coinciding with an ack
    // keeps irq asserted while the ack still clears overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
            ovr_r <= 1'b0;
        end else if (irq_ack && irq_r) begin
            irq_r <= fire;
            ovr_r <= 1'b0;
        end else if (fire) begin
            irq_r <= 1'b1;
            if (irq_r) begin
                ovr_r <= 1'b1;
            end
        end
    end

    assign irq     = irq_r;
    assign overrun = ovr_r;
    assign count   = count_r;

endmodule
